// File: rtl/z80_bus_capture.sv
// Passive Z80 bus monitor: one record per completed bus cycle, visible 1 clk after COMMIT, in a FWFT FIFO on rec_valid/rec_ready.
// A full FIFO without a pop drops the record and counts it. Define BUSCAP_RFSH_CAPTURE_EN to also record refresh cycles.
module z80_bus_capture #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             m1_n,
  input  logic             mreq_n,
  input  logic             iorq_n,
  input  logic             rd_n,
  input  logic             wr_n,
  input  logic             rfsh_n,
  input  logic [15:0]      A,
  input  logic [7:0]       di,
  input  logic [7:0]       dout,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [2:0]       rec_type,
  output logic [15:0]      rec_addr,
  output logic [7:0]       rec_data,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [2:0] T_OPFETCH = 3'd0, T_MEMRD = 3'd1, T_MEMWR = 3'd2, T_IORD = 3'd3,
                         T_IOWR = 3'd4, T_INTACK = 3'd5, T_REFRESH = 3'd6;

  typedef struct packed {
    logic [2:0]  typ;
    logic [15:0] addr;
    logic [7:0]  data;
  } rec_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;

  function automatic logic [7:0] pick_data(input logic [2:0] t, input logic [7:0] rdat,
                                           input logic [7:0] wdat);
    case (t)
      T_MEMWR, T_IOWR: return wdat;
      T_REFRESH:       return 8'h00;
      default:         return rdat;
    endcase
  endfunction

  logic        m1_q, mreq_q, iorq_q, rd_q, wr_q, rfsh_q;
  logic [15:0] a_q;
  logic [7:0]  di_q, dout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m1_q   <= 1'b1;
      mreq_q <= 1'b1;
      iorq_q <= 1'b1;
      rd_q   <= 1'b1;
      wr_q   <= 1'b1;
      rfsh_q <= 1'b1;
      a_q    <= '0;
      di_q   <= '0;
      dout_q <= '0;
    end else begin
      m1_q   <= m1_n;
      mreq_q <= mreq_n;
      iorq_q <= iorq_n;
      rd_q   <= rd_n;
      wr_q   <= wr_n;
      rfsh_q <= rfsh_n;
      a_q    <= A;
      di_q   <= di;
      dout_q <= dout;
    end
  end

  logic       act;
  logic [2:0] dec_type;

  always_comb begin
    act = (!mreq_q || !iorq_q) && (!rd_q || !wr_q || (!m1_q && !iorq_q)) && rfsh_q;
    if (!m1_q && !iorq_q)       dec_type = T_INTACK;
    else if (!m1_q && !mreq_q)  dec_type = T_OPFETCH;
    else if (!mreq_q && !wr_q)  dec_type = T_MEMWR;
    else if (!mreq_q)           dec_type = T_MEMRD;
    else if (!iorq_q && !wr_q)  dec_type = T_IOWR;
    else                        dec_type = T_IORD;
`ifdef BUSCAP_RFSH_CAPTURE_EN
    if (!rfsh_q && !mreq_q) begin
      act      = 1'b1;
      dec_type = T_REFRESH;
    end
`endif
  end

  state_t state, state_nxt;
  logic   latch_cyc, load_data, push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (act) state_nxt = ACTIVE;
      ACTIVE:  if (!act) state_nxt = COMMIT;
      COMMIT:  state_nxt = act ? ACTIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    latch_cyc = act && (state == IDLE || state == COMMIT);
    load_data = act && (state == ACTIVE);
    push      = (state == COMMIT);
  end

  logic [2:0]  cur_type;
  logic [15:0] cur_addr;
  logic [7:0]  cur_data;

  // Type and address are frozen at cycle start; data keeps tracking until the strobes drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_type <= '0;
      cur_addr <= '0;
      cur_data <= '0;
    end else if (latch_cyc) begin
      cur_type <= dec_type;
      cur_addr <= a_q;
      cur_data <= pick_data(dec_type, di_q, dout_q);
    end else if (load_data) begin
      cur_data <= pick_data(cur_type, di_q, dout_q);
    end
  end

  rec_t        mem [DEPTH];
  rec_t        head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr_en, drop;

  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop   = !empty && rec_ready;
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;
    head  = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= '{typ: cur_type, addr: cur_addr, data: cur_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // A drop in the same clock as clr still leaves a visible count of one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr)                             drop_cnt <= CNT_W'(1);
      else if (drop_cnt != {CNT_W{1'b1}})  drop_cnt <= drop_cnt + CNT_W'(1);
    end else if (clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  assign rec_valid = !empty;
  assign rec_type  = empty ? 3'd0  : head.typ;
  assign rec_addr  = empty ? 16'd0 : head.addr;
  assign rec_data  = empty ? 8'd0  : head.data;

endmodule

// File: doc/z80_bus_capture.md
Name: z80_bus_capture

Overview:
- Passive monitor downstream of the tv80s bus pins. It sits beside the behavioural memory/IO model in the CPU test benches.
- Decodes each completed CPU bus cycle into one transaction record: type, address, data.
- Records are buffered in a FIFO and delivered on a valid/ready stream. Checkers compare them against expected access sequences, e.g. the stack writes of PUSH IX.
- Never drives the CPU bus.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the dropped-record counter; saturates at max.

Ports:
- clk  in  1  CPU clock; all sampling on rising edge
- reset_n  in  1  asynchronous active-low reset
- m1_n  in  1  CPU M1
- mreq_n  in  1  CPU MREQ
- iorq_n  in  1  CPU IORQ
- rd_n  in  1  CPU RD
- wr_n  in  1  CPU WR
- rfsh_n  in  1  CPU RFSH
- A  in  16  CPU address bus
- di  in  8  data into CPU (read data)
- dout  in  8  data out of CPU (write data)
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_type  out  3  0 OPFETCH, 1 MEMRD, 2 MEMWR, 3 IORD, 4 IOWR, 5 INTACK, 6 REFRESH, 7 reserved
- rec_addr  out  16  address of cycle
- rec_data  out  8  data of cycle
- overflow  out  1  sticky: at least one record dropped
- drop_cnt  out  CNT_W  records dropped, saturating
- clr  in  1  synchronous clear of overflow and drop_cnt

Behaviour:
- Reset (async, reset_n low): FSM in IDLE, FIFO empty. rec_valid=0, rec_type=0, rec_addr=0, rec_data=0, overflow=0, drop_cnt=0.
- Cycle-active predicate act, evaluated on registered (1-clk) copies of the bus inputs: (mreq_n==0 or iorq_n==0) and (rd_n==0 or wr_n==0 or (m1_n==0 and iorq_n==0)).
- Refresh cycles (rfsh_n==0) never count as act unless BUSCAP_RFSH_CAPTURE_EN is set.
- Type decode, latched on the first act cycle, priority order:
  - m1_n=0 & iorq_n=0 -> INTACK
  - m1_n=0 & mreq_n=0 -> OPFETCH
  - mreq_n=0 & wr_n=0 -> MEMWR
  - mreq_n=0 -> MEMRD
  - iorq_n=0 & wr_n=0 -> IOWR
  - else IORD
- FSM states:
  - IDLE: on act -> ACTIVE; latch type and A.
  - ACTIVE: every clock with act, reload data (read types from di, write types from dout, INTACK from di). Last sample wins. On first clock with !act -> COMMIT.
  - COMMIT: push record, -> IDLE. If act is already true again in COMMIT (back-to-back cycles), start the new cycle directly: latch type/A, go to ACTIVE.
  - A change of type while in ACTIVE is ignored; A is not re-latched.
- Latency: record visible on rec_valid exactly 1 clk after COMMIT. This is 3 clks after the strobe-release edge at the pins.
- FIFO: first-word-fall-through; outputs are registered head entry.
  - Pop when rec_valid & rec_ready.
  - Push and pop in the same cycle on a full FIFO: both succeed, no drop.
  - Push on full without pop: record discarded, overflow<=1, drop_cnt increments and saturates at 2^CNT_W-1.
  - Pop on empty: no effect.
  - Pointers wrap modulo DEPTH; full/empty distinguished by an extra pointer bit.
- clr: overflow<=0, drop_cnt<=0 next clk. A drop in the same cycle wins: overflow=1, drop_cnt=1.
- reset_n asserted mid-cycle: in-flight record is lost and FIFO flushed. The first record after release comes from the next complete act interval. An act already true at release counts as a fresh cycle start.

Optional Feature:
- BUSCAP_RFSH_CAPTURE_EN defined: cycles with rfsh_n=0 & mreq_n=0 are captured as REFRESH, rec_addr=A, rec_data=8'h00.
- Undefined: refresh cycles produce no record and type code 6 is never emitted.

Test Plan:
- Reset, then run DD E5 at 0x0000 with SP=0761, IX=b282 -> exactly four records in order:
  - OPFETCH/0000/dd
  - OPFETCH/0001/e5
  - MEMWR/0760/b2
  - MEMWR/075f/82
  - then OPFETCH/0002 follows; no refresh records without the macro.
- Same program with BUSCAP_RFSH_CAPTURE_EN -> REFRESH records interleaved after each OPFETCH, data 00; R-based addr 0000 then 0001 in low byte.
- DEPTH=4, rec_ready held 0 for 6 cycles -> 4 records held, overflow=1, drop_cnt=2. Then rec_ready=1 -> first 4 records drain in original order.
- OUT (0x10),A with A=5a then IN A,(0x10) -> IOWR/xx10/5a followed by IORD/xx10/5a.
- Full FIFO with rec_ready=1 during a commit -> no drop, drop_cnt unchanged. Pulse clr while drop_cnt=0xff -> 0 next clk.
- reset_n pulsed low mid-MEMWR -> rec_valid=0 immediately (async). No partial record after release; next record is the following complete cycle.
